edge_window_gen: RTL and testbench

EDGE_WINDOW_GEN -- requirements
Module: edge_window_gen

---
 rtl/edge_pkg.sv | 18 +
 rtl/edge_line_buf.sv | 26 ++
 rtl/edge_window_gen.sv | 158 +++++++++++++++
 tb/tb_edge_window_gen.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_pkg.sv
// Shared types for the 3x3 edge-window generator: pixel/window typedefs and the
// fill/stream state encoding.
package edge_pkg;

  localparam int unsigned PIX_W_DEF = 8;
  localparam int unsigned WIN_N     = 9;
  localparam int unsigned WIN_CTR   = 4;

  typedef logic [PIX_W_DEF-1:0] pixel_t;
  // Packed so that element k sits at bits [PIX_W*k +: PIX_W]; k = 3*row + col.
  typedef pixel_t [WIN_N-1:0] window_t;

  typedef enum logic {
    FILL   = 1'b0,
    STREAM = 1'b1
  } state_t;

endpackage

// File: rtl/edge_line_buf.sv
// Single-port line buffer, read-before-write with combinational read.
// Ports: clk; addr (column); we (write strobe); wdata (new pixel);
//        rdata (value stored at addr before this cycle's write).
module edge_line_buf
  import edge_pkg::*;
#(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned DATA_W = PIX_W_DEF
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic                     we,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are not reset; every location is written before it is used.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/edge_window_gen.sv
// Raster-scan to 3x3 sliding-window generator for an edge-detection core.
// Ports: ACLK/ARESETN (async active-low reset);
//        s_tvalid/s_tready/s_tdata/s_tuser  pixel stream in (tuser = start of frame);
//        m_tvalid/m_tready/m_tdata/m_tlast  window stream out, m_tdata element
//          k = 3*row + col at bits [PIX_W*k +: PIX_W], row/col 0 = oldest;
//        frame_done  one-cycle pulse after the last pixel of a frame;
//        sof_err     sticky flag for a start-of-frame seen mid-frame.
module edge_window_gen
  import edge_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 64,
  parameter int unsigned IMG_HEIGHT = 64,
  parameter int unsigned PIX_W      = PIX_W_DEF
) (
  input  logic                   ACLK,
  input  logic                   ARESETN,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic [PIX_W-1:0]       s_tdata,
  input  logic                   s_tuser,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [WIN_N*PIX_W-1:0] m_tdata,
  output logic                   m_tlast,
  output logic                   frame_done,
  output logic                   sof_err
);

  localparam int unsigned COL_W = $clog2(IMG_WIDTH);
  localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  state_t state_q, state_d;

  logic [COL_W-1:0] col_q, eff_col;
  logic [ROW_W-1:0] row_q, eff_row;
  logic             accept, sof_mis, eol, eof, out_load;
  logic [PIX_W-1:0] new_rd, old_rd;

  logic [WIN_N-1:0][PIX_W-1:0] win_q, win_d, m_tdata_q;
  logic m_tvalid_q, m_tlast_q, frame_done_q, sof_err_q;

  // Single output register: a new pixel may enter whenever the held window leaves.
  assign s_tready = !m_tvalid_q || m_tready;
  assign accept   = s_tvalid && s_tready;

  // A misplaced start-of-frame restarts the frame at (0,0) for this very pixel.
  assign sof_mis = s_tuser && ((col_q != '0) || (row_q != '0));
  assign eff_col = sof_mis ? '0 : col_q;
  assign eff_row = sof_mis ? '0 : row_q;
  assign eol     = (eff_col == COL_LAST);
  assign eof     = eol && (eff_row == ROW_LAST);

  // lb_new holds row-1, lb_old holds row-2; lb_old is fed from lb_new's old value.
  edge_line_buf #(.DEPTH(IMG_WIDTH), .DATA_W(PIX_W)) u_lb_new (
    .clk   (ACLK),
    .addr  (eff_col),
    .we    (accept),
    .wdata (s_tdata),
    .rdata (new_rd)
  );

  edge_line_buf #(.DEPTH(IMG_WIDTH), .DATA_W(PIX_W)) u_lb_old (
    .clk   (ACLK),
    .addr  (eff_col),
    .we    (accept),
    .wdata (new_rd),
    .rdata (old_rd)
  );

  // State register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state_q <= FILL;
    else          state_q <= state_d;
  end

  // Next state: stream from the start of row 2 until the frame ends or restarts.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      if (sof_mis || eof) begin
        state_d = FILL;
      end else if ((eff_row == ROW_W'(2)) && (eff_col == '0)) begin
        state_d = STREAM;
      end
    end
  end

  // Output decode: a window exists once two full columns precede this pixel.
  always_comb begin
    out_load = 1'b0;
    if (accept && (state_q == STREAM) && (eff_col >= COL_W'(2))) begin
      out_load = 1'b1;
    end
  end

  // Window shifts one column left; the new rightmost column is {row-2, row-1, row}.
  always_comb begin
    win_d    = win_q;
    win_d[0] = win_q[1];
    win_d[1] = win_q[2];
    win_d[2] = old_rd;
    win_d[3] = win_q[4];
    win_d[4] = win_q[5];
    win_d[5] = new_rd;
    win_d[6] = win_q[7];
    win_d[7] = win_q[8];
    win_d[8] = s_tdata;
  end

  // Raster position of the next pixel.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      col_q <= '0;
      row_q <= '0;
    end else if (accept) begin
      if (eol) begin
        col_q <= '0;
        row_q <= eof ? '0 : ROW_W'(eff_row + ROW_W'(1));
      end else begin
        col_q <= COL_W'(eff_col + COL_W'(1));
        row_q <= eff_row;
      end
    end
  end

  // Window register, output register and status flags.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      win_q        <= '0;
      m_tdata_q    <= '0;
      m_tvalid_q   <= 1'b0;
      m_tlast_q    <= 1'b0;
      frame_done_q <= 1'b0;
      sof_err_q    <= 1'b0;
    end else begin
      frame_done_q <= accept && eof;
      if (accept && sof_mis) sof_err_q <= 1'b1;
      if (accept) win_q <= win_d;
      if (out_load) begin
        m_tvalid_q <= 1'b1;
        m_tdata_q  <= win_d;
        m_tlast_q  <= eol;
      end else if (m_tready) begin
        m_tvalid_q <= 1'b0;
        m_tlast_q  <= 1'b0;
      end
    end
  end

  assign m_tvalid   = m_tvalid_q;
  assign m_tdata    = m_tdata_q;
  assign m_tlast    = m_tlast_q;
  assign frame_done = frame_done_q;
  assign sof_err    = sof_err_q;

endmodule

// File: tb/tb_edge_window_gen.sv
// Self-checking bench for edge_window_gen with a 4x4 image of 8-bit pixels.
module tb_edge_window_gen;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 4;
  localparam int unsigned PW = 8;

  logic          ACLK = 1'b0;
  logic          ARESETN;
  logic          s_tvalid, s_tready, s_tuser;
  logic [PW-1:0] s_tdata;
  logic          m_tvalid, m_tready, m_tlast;
  logic [71:0]   m_tdata;
  logic          frame_done, sof_err;

  always #5 ACLK = ~ACLK;

  edge_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(PW)) dut (
    .ACLK       (ACLK),
    .ARESETN    (ARESETN),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .s_tdata    (s_tdata),
    .s_tuser    (s_tuser),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tdata    (m_tdata),
    .m_tlast    (m_tlast),
    .frame_done (frame_done),
    .sof_err    (sof_err)
  );

  int checks = 0;
  int errors = 0;
  int acc_cyc = 0;
  bit rnd = 1'b0;

  logic [71:0] got_d[$];
  logic        got_l[$];
  logic [71:0] exp_d[$];
  logic        exp_l[$];
  int          done_cnt = 0;

  // Transfers and frame_done pulses are observed mid-cycle, ahead of the edge.
  always @(negedge ACLK) begin
    if (ARESETN) begin
      if (m_tvalid && m_tready) begin
        got_d.push_back(m_tdata);
        got_l.push_back(m_tlast);
      end
      if (frame_done) done_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Window whose newest pixel has value p, in an image whose values run sequentially.
  function automatic logic [71:0] win(int p);
    logic [8:0][7:0] w;
    for (int k = 0; k < 9; k++) w[4'(k)] = 8'(p - (2 - k / 3) * 4 - (2 - k % 3));
    return w;
  endfunction

  task automatic check(string name, logic [71:0] act, logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_reset();
    ARESETN  = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tuser  = 1'b0;
    m_tready = 1'b1;
    repeat (2) tick();
    ARESETN = 1'b1;
    tick();
  endtask

  // Offer one pixel until it is accepted (random valid/ready gaps when rnd is set).
  task automatic send(int v, logic u);
    bit acc;
    int g;
    acc = 1'b0;
    g   = 0;
    while (!acc && g < 100) begin
      s_tvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      s_tdata  = 8'(v);
      s_tuser  = u;
      if (rnd) m_tready = 1'($urandom_range(0, 1));
      @(negedge ACLK);
      acc = s_tvalid && s_tready;
      tick();
      g++;
      acc_cyc++;
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout: pixel %0d not accepted, required acceptance", v);
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    while (m_tvalid && g < 100) begin
      m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      g++;
    end
    m_tready = 1'b1;
    check("drain", 72'(m_tvalid), 72'(0));
    tick();
  endtask

  task automatic expect_frame(int base);
    for (int r = 2; r < 4; r++)
      for (int c = 2; c < 4; c++) begin
        exp_d.push_back(win(base + r * 4 + c));
        exp_l.push_back(c == 3);
      end
  endtask

  task automatic compare_stream(string name, int gbase);
    check({name, "_count"}, 72'(got_d.size() - gbase), 72'(exp_d.size()));
    for (int i = 0; i < exp_d.size(); i++) begin
      if (gbase + i < got_d.size()) begin
        check({name, "_win"}, got_d[gbase + i], exp_d[i]);
        check({name, "_last"}, 72'(got_l[gbase + i]), 72'(exp_l[i]));
      end
    end
    exp_d.delete();
    exp_l.delete();
  endtask

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       u;
    logic       rdy;
    logic       e_mv;
    logic       e_last;
    logic       e_done;
    int         e_p;
  } vec_t;

  vec_t tbl[18];

  initial begin
    int gbase, d0;

    // Single frame 0..15, always ready: windows after pixels 10, 11, 14, 15.
    for (int i = 0; i < 16; i++)
      tbl[i] = '{1'b1, 8'(i), (i == 0), 1'b1,
                 (i == 10 || i == 11 || i == 14 || i == 15),
                 (i == 11 || i == 15), (i == 15), i};
    tbl[16] = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[17] = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};

    do_reset();
    check("rst_m_tvalid", 72'(m_tvalid), 72'(0));
    check("rst_m_tdata", m_tdata, 72'(0));
    check("rst_m_tlast", 72'(m_tlast), 72'(0));
    check("rst_frame_done", 72'(frame_done), 72'(0));
    check("rst_sof_err", 72'(sof_err), 72'(0));
    check("rst_s_tready", 72'(s_tready), 72'(1));

    for (int i = 0; i < 18; i++) begin
      s_tvalid = tbl[i].v;
      s_tdata  = tbl[i].d;
      s_tuser  = tbl[i].u;
      m_tready = tbl[i].rdy;
      tick();
      check($sformatf("t1_mvalid[%0d]", i), 72'(m_tvalid), 72'(tbl[i].e_mv));
      check($sformatf("t1_mlast[%0d]", i), 72'(m_tlast), 72'(tbl[i].e_last));
      check($sformatf("t1_done[%0d]", i), 72'(frame_done), 72'(tbl[i].e_done));
      check($sformatf("t1_sready[%0d]", i), 72'(s_tready), 72'(1));
      if (tbl[i].e_mv) check($sformatf("t1_data[%0d]", i), m_tdata, win(tbl[i].e_p));
    end

    // Back-pressure on the first window: input stalls, window held, nothing lost.
    gbase = got_d.size();
    for (int i = 0; i <= 10; i++) send(i, (i == 0));
    check("t2_first_valid", 72'(m_tvalid), 72'(1));
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = 8'd11;
    s_tuser  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge ACLK);
      check("t2_stall_sready", 72'(s_tready), 72'(0));
      tick();
      check("t2_stall_valid", 72'(m_tvalid), 72'(1));
      check("t2_stall_data", m_tdata, win(10));
    end
    m_tready = 1'b1;
    for (int i = 11; i < 16; i++) send(i, 1'b0);
    drain();
    expect_frame(0);
    compare_stream("t2", gbase);

    // Two frames back to back: one cycle per pixel, second frame offset by 16.
    gbase   = got_d.size();
    d0      = done_cnt;
    acc_cyc = 0;
    for (int i = 0; i < 32; i++) send(i, (i % 16 == 0));
    check("t3_cycles", 72'(acc_cyc), 72'(32));
    drain();
    expect_frame(0);
    expect_frame(16);
    compare_stream("t3", gbase);
    check("t3_frames", 72'(done_cnt - d0), 72'(2));

    // Start-of-frame on pixel 6 restarts the frame there.
    gbase = got_d.size();
    d0    = done_cnt;
    check("t4_sof_before", 72'(sof_err), 72'(0));
    for (int i = 0; i < 22; i++) send(i, (i == 0 || i == 6));
    drain();
    check("t4_sof_err", 72'(sof_err), 72'(1));
    expect_frame(6);
    compare_stream("t4", gbase);
    check("t4_frames", 72'(done_cnt - d0), 72'(1));

    // Reset mid-frame while a window is held; then a fresh frame.
    for (int i = 0; i <= 10; i++) send(i, (i == 0));
    check("t5_pre_valid", 72'(m_tvalid), 72'(1));
    ARESETN  = 1'b0;
    s_tvalid = 1'b0;
    #1;
    check("t5_rst_m_tvalid", 72'(m_tvalid), 72'(0));
    check("t5_rst_m_tdata", m_tdata, 72'(0));
    check("t5_rst_m_tlast", 72'(m_tlast), 72'(0));
    check("t5_rst_frame_done", 72'(frame_done), 72'(0));
    check("t5_rst_sof_err", 72'(sof_err), 72'(0));
    tick();
    tick();
    ARESETN = 1'b1;
    tick();
    check("t5_s_tready", 72'(s_tready), 72'(1));
    gbase = got_d.size();
    d0    = done_cnt;
    for (int i = 0; i < 16; i++) send(i, (i == 0));
    drain();
    expect_frame(0);
    compare_stream("t5", gbase);
    check("t5_frames", 72'(done_cnt - d0), 72'(1));

    // Random valid/ready over three frames.
    gbase = got_d.size();
    d0    = done_cnt;
    rnd   = 1'b1;
    for (int i = 0; i < 48; i++) send(i, (i % 16 == 0));
    drain();
    rnd      = 1'b0;
    m_tready = 1'b1;
    expect_frame(0);
    expect_frame(16);
    expect_frame(32);
    compare_stream("t6", gbase);
    check("t6_frames", 72'(done_cnt - d0), 72'(3));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
